// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 native-interface memory responder.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_e;

  localparam logic [31:0] ERR_RDATA            = 32'hDEAD_BEEF;
  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;
  localparam int unsigned WAIT_W               = 4;

  // Word-address width needed to index a RAM of the given depth.
  function automatic int unsigned ram_addr_width(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/mem_bram_be.sv
// Single-port 32-bit RAM with byte enables and registered read; no reset so it maps onto block RAM.
module mem_bram_be #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Read-first port: the read word reflects contents before any write on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/picorv32_mem_responder.sv
// Responder for the picorv32 native memory bus: block RAM, console byte port, programmable wait states.
// Optional macro MEMRESP_ADDR_CHECK_EN: unmapped accesses complete with DEAD_BEEF / discarded writes and an err pulse.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic [31:0] fetch_count,
  output logic        err
);

  localparam int unsigned AW = ram_addr_width(MEM_WORDS);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              instr_q, instr_d;
  logic              rd_ram_q, rd_ram_d;
  logic              rd_err_q, rd_err_d;
  logic              bad_q, bad_d;
  logic              con_wr_q, con_wr_d;
  logic [7:0]        con_byte_q, con_byte_d;
  logic              mem_ready_q, mem_ready_d;
  logic              console_valid_q, console_valid_d;
  logic [7:0]        console_data_q, console_data_d;
  logic              err_q, err_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic              hit_con_c;
  logic              bad_c;
  logic              start_c;
  logic [3:0]        ram_we_c;
  logic [31:0]       ram_rdata;
  logic              unused_addr_lsb;

  assign hit_con_c = (mem_addr[31:2] == CONSOLE_ADDR[31:2]);

`ifdef MEMRESP_ADDR_CHECK_EN
  logic hit_ram_c;
  assign hit_ram_c = (mem_addr[31:2] < 30'(MEM_WORDS));
  assign bad_c     = !hit_ram_c && !hit_con_c;
`else
  assign bad_c     = 1'b0;
`endif

  assign unused_addr_lsb = ^mem_addr[1:0];

  // The RAM is accessed on the same edge the request is accepted in IDLE.
  assign start_c  = (state_q == ST_IDLE) && mem_valid;
  assign ram_we_c = (hit_con_c || bad_c) ? 4'b0000 : mem_wstrb;

  mem_bram_be #(.AW(AW)) u_ram (
    .clk   (clk),
    .en    (start_c),
    .we    (ram_we_c),
    .addr  (mem_addr[AW+1:2]),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    instr_d         = instr_q;
    rd_ram_d        = rd_ram_q;
    rd_err_d        = rd_err_q;
    bad_d           = bad_q;
    con_wr_d        = con_wr_q;
    con_byte_d      = con_byte_q;
    console_data_d  = console_data_q;
    fetch_count_d   = fetch_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          instr_d    = mem_instr;
          rd_ram_d   = (mem_wstrb == 4'b0000) && !hit_con_c && !bad_c;
          rd_err_d   = (mem_wstrb == 4'b0000) && bad_c;
          bad_d      = bad_c;
          con_wr_d   = hit_con_c && mem_wstrb[0];
          con_byte_d = mem_wdata[7:0];
          wcnt_d     = WAIT_W'(WAIT_STATES - 1);
          state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_RESP;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      ST_RESP: begin
        state_d = ST_GAP;
        if (instr_q) fetch_count_d = fetch_count_q + 32'd1;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pulses are registered so they are high exactly while the FSM sits in RESP.
    mem_ready_d     = (state_d == ST_RESP);
    console_valid_d = (state_d == ST_RESP) && con_wr_d;
    err_d           = (state_d == ST_RESP) && bad_d;
    if (console_valid_d) console_data_d = con_byte_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      wcnt_q          <= '0;
      instr_q         <= 1'b0;
      rd_ram_q        <= 1'b0;
      rd_err_q        <= 1'b0;
      bad_q           <= 1'b0;
      con_wr_q        <= 1'b0;
      con_byte_q      <= '0;
      mem_ready_q     <= 1'b0;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      err_q           <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      instr_q         <= instr_d;
      rd_ram_q        <= rd_ram_d;
      rd_err_q        <= rd_err_d;
      bad_q           <= bad_d;
      con_wr_q        <= con_wr_d;
      con_byte_q      <= con_byte_d;
      mem_ready_q     <= mem_ready_d;
      console_valid_q <= console_valid_d;
      console_data_q  <= console_data_d;
      err_q           <= err_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  // Read data is gated by the ready flop; writes and console reads return zero.
  assign mem_rdata     = !mem_ready_q ? 32'h0 :
                         rd_ram_q     ? ram_rdata :
                         rd_err_q     ? ERR_RDATA : 32'h0;
  assign mem_ready     = mem_ready_q;
  assign console_valid = console_valid_q;
  assign console_data  = console_data_q;
  assign fetch_count   = fetch_count_q;
`ifdef MEMRESP_ADDR_CHECK_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench: one responder with no wait states and one with three, checked through a scoreboard queue.
module tb_picorv32_mem_responder;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst3 = 1'b1;
  logic        valid0 = 1'b0, valid3 = 1'b0;
  logic        instr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        ready0, ready3, cv0, cv3, err0, err3;
  logic [31:0] rdata0, rdata3, fc0, fc3;
  logic [7:0]  cd0, cd3;

  logic        sel = 1'b0;
  logic        r_ready, r_cv, r_err;
  logic [31:0] r_rdata;
  logic [7:0]  r_cd;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  picorv32_mem_responder #(.MEM_WORDS(4096), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .mem_valid(valid0), .mem_instr(instr), .mem_ready(ready0),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata0),
    .console_valid(cv0), .console_data(cd0), .fetch_count(fc0), .err(err0)
  );

  picorv32_mem_responder #(.MEM_WORDS(4096), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst3), .mem_valid(valid3), .mem_instr(instr), .mem_ready(ready3),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata3),
    .console_valid(cv3), .console_data(cd3), .fetch_count(fc3), .err(err3)
  );

  assign r_ready = sel ? ready3 : ready0;
  assign r_rdata = sel ? rdata3 : rdata0;
  assign r_cv    = sel ? cv3    : cv0;
  assign r_cd    = sel ? cd3    : cd0;
  assign r_err   = sel ? err3   : err0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: valid held through ready and the following gap cycle; bus inputs scrambled while busy.
  task automatic txn(input logic s, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic ins, input logic [31:0] exp_rd, input int exp_lat,
                     input logic exp_cv, input logic [7:0] exp_cd, input logic exp_err, input string tag);
    int lat;
    logic [31:0] want;
    sel = s; addr = a; wdata = wd; wstrb = ws; instr = ins;
    if (s) valid3 = 1'b1; else valid0 = 1'b1;
    sb_q.push_back(exp_rd);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      addr = ~a; wdata = $urandom; wstrb = ~ws;
    end while (!r_ready && lat < 40);
    want = sb_q.pop_front();
    chk({tag, " ready"},   32'(r_ready), 32'd1);
    chk({tag, " latency"}, 32'(lat),     32'(exp_lat));
    chk({tag, " rdata"},   r_rdata,      want);
    chk({tag, " console_valid"}, 32'(r_cv), 32'(exp_cv));
    if (exp_cv) chk({tag, " console_data"}, 32'(r_cd), 32'(exp_cd));
    chk({tag, " err"}, 32'(r_err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, " gap ready"}, 32'(r_ready), 32'd0);
    chk({tag, " gap console_valid"}, 32'(r_cv), 32'd0);
    valid0 = 1'b0; valid3 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] oor_rd, oor_word0;
    logic        oor_err;
`ifdef MEMRESP_ADDR_CHECK_EN
    oor_rd = 32'hDEAD_BEEF; oor_err = 1'b1; oor_word0 = 32'h1122_3344;
`else
    oor_rd = 32'h1122_3344; oor_err = 1'b0; oor_word0 = 32'h9999_9999;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready",  32'(ready0), 32'd0);
    chk("rst rdata",  rdata0,      32'd0);
    chk("rst cv",     32'(cv0),    32'd0);
    chk("rst cd",     32'(cd0),    32'd0);
    chk("rst fc",     fc0,         32'd0);
    chk("rst err",    32'(err0),   32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    txn(0, 32'h40, 32'hA1B2_C3D4, 4'b1111, 0, 32'h0,         1, 0, 8'h00, 0, "wr40");
    txn(0, 32'h40, 32'h0,         4'b0000, 0, 32'hA1B2_C3D4, 1, 0, 8'h00, 0, "rd40");
    txn(0, 32'h40, 32'h0000_00EE, 4'b0001, 0, 32'h0,         1, 0, 8'h00, 0, "wr40b");
    txn(0, 32'h40, 32'h0,         4'b0000, 0, 32'hA1B2_C3EE, 1, 0, 8'h00, 0, "rd40b");
    txn(0, 32'h43, 32'h0,         4'b0000, 0, 32'hA1B2_C3EE, 1, 0, 8'h00, 0, "rd43");
    txn(0, 32'h0,  32'h1122_3344, 4'b1111, 0, 32'h0,         1, 0, 8'h00, 0, "wr0");
    txn(0, 32'h1000_0000, 32'hFFFF_FF48, 4'b0001, 0, 32'h0,  1, 1, 8'h48, 0, "con_wr");
    txn(0, 32'h0,  32'h0,         4'b0000, 0, 32'h1122_3344, 1, 0, 8'h00, 0, "rd0 after con");
    txn(0, 32'h1000_0000, 32'h0,  4'b0000, 0, 32'h0,         1, 0, 8'h00, 0, "con_rd");
    chk("console_data hold", 32'(cd0), 32'h48);

    for (int i = 0; i < 5; i++)
      txn(0, 32'h40, 32'h0, 4'b0000, 1, 32'hA1B2_C3EE, 1, 0, 8'h00, 0, "fetch");
    txn(0, 32'h0,  32'h0, 4'b0000, 0, 32'h1122_3344, 1, 0, 8'h00, 0, "data rd a");
    txn(0, 32'h40, 32'h0, 4'b0000, 0, 32'hA1B2_C3EE, 1, 0, 8'h00, 0, "data rd b");
    chk("fetch_count5", fc0, 32'd5);

    txn(0, 32'h8000_0000, 32'h0,         4'b0000, 0, oor_rd, 1, 0, 8'h00, oor_err, "oor rd");
    txn(0, 32'h8000_0000, 32'h9999_9999, 4'b1111, 0, 32'h0,  1, 0, 8'h00, oor_err, "oor wr");
    txn(0, 32'h0,         32'h0,         4'b0000, 0, oor_word0, 1, 0, 8'h00, 0, "rd0 after oor");
    chk("fetch_count after oor", fc0, 32'd5);

    txn(1, 32'h100, 32'hCAFE_F00D, 4'b1111, 0, 32'h0,         4, 0, 8'h00, 0, "ws3 wr");
    txn(1, 32'h100, 32'h0,         4'b0000, 1, 32'hCAFE_F00D, 4, 0, 8'h00, 0, "ws3 fetch");
    chk("ws3 fetch_count", fc3, 32'd1);

    // Reset lands while the second responder is counting wait states.
    sel = 1'b1; addr = 32'h100; wdata = '0; wstrb = 4'b0000; instr = 1'b1; valid3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid ready before reset", 32'(ready3), 32'd0);
    rst3 = 1'b1; valid3 = 1'b0;
    #1;
    chk("reset ready", 32'(ready3), 32'd0);
    chk("reset fetch_count", fc3, 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post reset no ready", 32'(ready3), 32'd0);
    end
    chk("post reset fetch_count", fc3, 32'd0);
    txn(1, 32'h100, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 4, 0, 8'h00, 0, "ws3 rd after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
